// File: rtl/dpram_responder.sv
// Memory-side responder for the RD/WR/Done four-phase strobe handshake over an on-chip RAM.
// Optional feature: define DPRAM_PARITY_EN to store an even-parity bit per word and report ParErr.
module dpram_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              ar,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] DIn,
    input  logic              RD,
    input  logic              WR,
    output logic [DATA_W-1:0] DOut,
    output logic              Done,
    output logic              Busy
`ifdef DPRAM_PARITY_EN
    ,
    output logic              ParErr
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 3;
`ifdef DPRAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [MEM_W-1:0]  r_mem [DEPTH];

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_wr_op;
    logic [DATA_W-1:0] r_dout;
    logic              r_done;
    logic              r_busy;
    logic              r_parerr;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_din_nxt;
    logic              w_wr_op_nxt;
    logic [DATA_W-1:0] w_dout_nxt;
    logic              w_done_nxt;
    logic              w_busy_nxt;
    logic              w_parerr_nxt;
    logic              w_commit_wr;
    logic [MEM_W-1:0]  w_rd_word;
    logic [MEM_W-1:0]  w_wr_word;
    logic              w_par_bad;

    assign w_rd_word = r_mem[r_addr];

`ifdef DPRAM_PARITY_EN
    assign w_wr_word = {^r_din, r_din};
    assign w_par_bad = w_rd_word[DATA_W] != (^w_rd_word[DATA_W-1:0]);
`else
    assign w_wr_word = r_din;
    assign w_par_bad = 1'b0;
`endif

    // Handshake FSM state and registered outputs
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_wr_op  <= 1'b0;
            r_dout   <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_parerr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_din    <= w_din_nxt;
            r_wr_op  <= w_wr_op_nxt;
            r_dout   <= w_dout_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_parerr <= w_parerr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_din_nxt    = r_din;
        w_wr_op_nxt  = r_wr_op;
        w_dout_nxt   = r_dout;
        w_done_nxt   = r_done;
        w_busy_nxt   = r_busy;
        w_parerr_nxt = r_parerr;
        w_commit_wr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // WR wins when both strobes are high
                if (RD || WR) begin
                    w_addr_nxt   = A;
                    w_din_nxt    = DIn;
                    w_wr_op_nxt  = WR;
                    w_cnt_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_parerr_nxt = 1'b0;
                    w_state_nxt  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    if (r_wr_op) begin
                        w_commit_wr = 1'b1;
                    end else begin
                        w_dout_nxt   = w_rd_word[DATA_W-1:0];
                        w_parerr_nxt = w_par_bad;
                    end
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Strobes held high keep Done asserted; no re-accept until both drop
                if (!(RD || WR)) begin
                    w_done_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // RAM array is never reset so contents survive ar
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            r_mem[r_addr] <= w_wr_word;
        end
    end

    assign DOut = r_dout;
    assign Done = r_done;
    assign Busy = r_busy;
`ifdef DPRAM_PARITY_EN
    assign ParErr = r_parerr;
`endif

endmodule

// File: tb/tb_dpram_responder.sv
// Directed self-checking bench for dpram_responder (WAIT_CYCLES=2).
// ParErr checks are compiled in only when DPRAM_PARITY_EN is defined.
module tb_dpram_responder;

    logic        clk;
    logic        ar;
    logic [9:0]  A;
    logic [15:0] DIn;
    logic        RD;
    logic        WR;
    logic [15:0] DOut;
    logic        Done;
    logic        Busy;
`ifdef DPRAM_PARITY_EN
    logic        ParErr;
`endif

    int n_total = 0;
    int n_pass  = 0;

    dpram_responder #(
        .ADDR_W      (10),
        .DATA_W      (16),
        .WAIT_CYCLES (2)
    ) dut (
        .clk  (clk),
        .ar   (ar),
        .A    (A),
        .DIn  (DIn),
        .RD   (RD),
        .WR   (WR),
        .DOut (DOut),
        .Done (Done),
        .Busy (Busy)
`ifdef DPRAM_PARITY_EN
        ,
        .ParErr (ParErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full four-phase access; returns DOut sampled while Done is high
    task automatic run_access(input logic wr, input logic [9:0] a, input logic [15:0] d,
                              output logic [15:0] dout);
        bit seen;
        int n;
        seen = 1'b0;
        n    = 0;
        step();
        A   = a;
        DIn = d;
        WR  = wr;
        RD  = !wr;
        while (!seen && n < 16) begin
            step();
            n++;
            if (Done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        dout = DOut;
        WR   = 1'b0;
        RD   = 1'b0;
        step();
        chk("idle_busy", 32'(Busy), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        ar  = 1'b1;
        A   = '0;
        DIn = '0;
        RD  = 1'b0;
        WR  = 1'b0;
        #12;
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_dout", 32'(DOut), 32'd0);
`ifdef DPRAM_PARITY_EN
        chk("rst_parerr", 32'(ParErr), 32'd0);
`endif
        ar = 1'b0;

        // Write latency: accept at edge N, Done visible after N+2
        step();
        A   = 10'h155;
        DIn = 16'hBEEF;
        WR  = 1'b1;
        step();
        chk("wr_n_busy", 32'(Busy), 32'd1);
        chk("wr_n_done", 32'(Done), 32'd0);
        step();
        chk("wr_n1_done", 32'(Done), 32'd0);
        step();
        chk("wr_n2_done", 32'(Done), 32'd1);
        WR = 1'b0;
        step();
        chk("wr_ret_done", 32'(Done), 32'd0);
        chk("wr_ret_busy", 32'(Busy), 32'd0);

        run_access(1'b0, 10'h155, 16'h0000, rd);
        chk("rd_155", 32'(rd), 32'hBEEF);
        chk("rd_155_held", 32'(DOut), 32'hBEEF);

        // Boundary addresses
        run_access(1'b1, 10'h000, 16'h1234, rd);
        run_access(1'b1, 10'h3FF, 16'hABCD, rd);
        run_access(1'b0, 10'h000, 16'h0000, rd);
        chk("rd_000", 32'(rd), 32'h1234);
        run_access(1'b0, 10'h3FF, 16'h0000, rd);
        chk("rd_3ff", 32'(rd), 32'hABCD);

        // Both strobes high is a write
        step();
        A   = 10'h020;
        DIn = 16'h5A5A;
        WR  = 1'b1;
        RD  = 1'b1;
        step();
        step();
        step();
        chk("both_done", 32'(Done), 32'd1);
        WR = 1'b0;
        RD = 1'b0;
        step();
        run_access(1'b0, 10'h020, 16'h0000, rd);
        chk("rd_020", 32'(rd), 32'h5A5A);

        // Strobe held 20 cycles past Done; DIn change after accept ignored
        step();
        A   = 10'h040;
        DIn = 16'h1111;
        WR  = 1'b1;
        step();
        DIn = 16'h2222;
        A   = 10'h041;
        step();
        step();
        chk("hold_done0", 32'(Done), 32'd1);
        begin
            int stuck;
            stuck = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (!Done || !Busy) stuck++;
            end
            chk("hold_done_busy", 32'(stuck), 32'd0);
        end
        WR = 1'b0;
        step();
        chk("hold_release", 32'(Done), 32'd0);
        run_access(1'b0, 10'h040, 16'h0000, rd);
        chk("rd_040", 32'(rd), 32'h1111);
        run_access(1'b0, 10'h041, 16'h0000, rd);
        chk("rd_041_untouched", 32'(rd == 16'h2222), 32'd0);
        run_access(1'b0, 10'h040, 16'h0000, rd);

        // Reset on first ACCESS cycle aborts the write
        step();
        A   = 10'h020;
        DIn = 16'hFFFF;
        WR  = 1'b1;
        step();
        ar = 1'b1;
        #1;
        chk("arst_done", 32'(Done), 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_dout", 32'(DOut), 32'd0);
        WR = 1'b0;
        step();
        step();
        ar = 1'b0;
        run_access(1'b0, 10'h020, 16'h0000, rd);
        chk("rd_020_after_rst", 32'(rd), 32'h5A5A);

        // Strobe dropped during ACCESS: Done pulses one cycle
        step();
        A  = 10'h000;
        RD = 1'b1;
        step();
        RD = 1'b0;
        step();
        chk("drop_n1_done", 32'(Done), 32'd0);
        step();
        chk("drop_n2_done", 32'(Done), 32'd1);
        chk("drop_dout", 32'(DOut), 32'h1234);
        step();
        chk("drop_n3_done", 32'(Done), 32'd0);
        chk("drop_n3_busy", 32'(Busy), 32'd0);

`ifdef DPRAM_PARITY_EN
        run_access(1'b1, 10'h010, 16'h0001, rd);
        dut.r_mem[16][0] = ~dut.r_mem[16][0];
        run_access(1'b0, 10'h010, 16'h0000, rd);
        chk("par_bad", 32'(ParErr), 32'd1);
        run_access(1'b0, 10'h155, 16'h0000, rd);
        chk("par_clean", 32'(ParErr), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
